// File: rtl/bram_host_master.sv
// Host-side command initiator for a BRAM-style control port plus the TPU start/done handshake.
// Optional WAIT_DONE timeout is built when BRAM_HOST_TIMEOUT_EN is defined.
module bram_host_master #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    input  logic [3:0]        cmd_be_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_timeout_o,
    output logic [ADDR_W-1:0] addr_a_o,
    output logic [DATA_W-1:0] wrdata_a_o,
    output logic              en_a_o,
    output logic [3:0]        we_a_o,
    input  logic [DATA_W-1:0] rddata_a_i,
    output logic              start_o,
    input  logic              done_i
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_START = 2'b10;
    localparam logic [1:0] OP_WAIT  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        STRT,
        WAIT_DONE,
        RESP
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]        op_reg;
    logic [3:0]        be_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [1:0]        lat_cnt_reg;
    logic              done_seen_reg;
    logic              accept;
    logic              done_hit;
    logic              to_hit;

    assign accept   = (state_reg == IDLE) && cmd_valid_i && !rst;
    assign done_hit = done_seen_reg || done_i;

    assign addr_a_o    = addr_reg;
    assign wrdata_a_o  = wdata_reg;
    assign rsp_rdata_o = rdata_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cmd_ready_o = 1'b0;
        en_a_o      = 1'b0;
        we_a_o      = 4'b0000;
        start_o     = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready_o = !rst;
                if (accept) begin
                    case (cmd_op_i)
                        OP_WRITE: state_next = WR;
                        OP_READ:  state_next = RD_ISSUE;
                        OP_START: state_next = STRT;
                        default:  state_next = WAIT_DONE;
                    endcase
                end
            end
            WR: begin
                en_a_o     = 1'b1;
                we_a_o     = be_reg;
                state_next = RESP;
            end
            RD_ISSUE: begin
                en_a_o     = 1'b1;
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                // Last wait cycle is the one where the BRAM data is valid.
                if (lat_cnt_reg == 2'(RD_LATENCY - 1)) begin
                    state_next = RESP;
                end
            end
            STRT: begin
                start_o    = 1'b1;
                state_next = RESP;
            end
            WAIT_DONE: begin
                if (done_hit || to_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg        <= OP_WRITE;
            be_reg        <= 4'b0000;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            lat_cnt_reg   <= 2'd0;
            done_seen_reg <= 1'b0;
        end else begin
            if (accept) begin
                op_reg <= cmd_op_i;
                // Port address/data only follow memory commands so they hold otherwise.
                if (cmd_op_i == OP_WRITE || cmd_op_i == OP_READ) begin
                    addr_reg <= cmd_addr_i;
                end
                if (cmd_op_i == OP_WRITE) begin
                    wdata_reg <= cmd_wdata_i;
                    be_reg    <= cmd_be_i;
                end
            end
            if (state_reg == RD_ISSUE) begin
                lat_cnt_reg <= 2'd0;
            end else if (state_reg == RD_WAIT) begin
                lat_cnt_reg <= lat_cnt_reg + 2'd1;
            end
            if (state_next == RESP) begin
                rdata_reg <= (op_reg == OP_READ) ? rddata_a_i : '0;
            end
            // A start re-arms the done catcher; clearing beats a coincident done.
            if (state_reg == STRT) begin
                done_seen_reg <= 1'b0;
            end else if (state_reg == WAIT_DONE && state_next == RESP) begin
                done_seen_reg <= 1'b0;
            end else if (done_i) begin
                done_seen_reg <= 1'b1;
            end
        end
    end

`ifdef BRAM_HOST_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] wait_cnt_reg;
    logic                 timeout_reg;

    // Fires on the cycle whose increment would make the counter all-ones.
    assign to_hit = (state_reg == WAIT_DONE) && !done_hit && (wait_cnt_reg == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            if (accept) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == WAIT_DONE) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
            if (state_next == RESP) begin
                timeout_reg <= to_hit;
            end
        end
    end

    assign rsp_timeout_o = timeout_reg && (state_reg == RESP);
`else
    assign to_hit        = 1'b0;
    assign rsp_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_bram_host_master.sv
// Randomized bench for bram_host_master: command-level reference model, latency-accurate BRAM model.
module tb_bram_host_master;

    localparam int AW = 22;
    localparam int DW = 32;
    localparam int L  = 3;
    localparam int TW = 4;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_START = 2'b10;
    localparam logic [1:0] OP_WAIT  = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_be;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_timeout;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] wrdata_a;
    logic          en_a;
    logic [3:0]    we_a;
    logic [DW-1:0] rddata_a;
    logic          start;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    bram_host_master #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_be_i(cmd_be),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_timeout_o(rsp_timeout),
        .addr_a_o(addr_a), .wrdata_a_o(wrdata_a), .en_a_o(en_a), .we_a_o(we_a),
        .rddata_a_i(rddata_a), .start_o(start), .done_i(done)
    );

    always #5 clk = ~clk;

    // BRAM model: 16 words indexed by addr[3:0], read data valid only L cycles after en.
    logic [DW-1:0] bmem [16];
    logic [DW-1:0] dpipe [L];
    logic          vpipe [L];
    logic [DW-1:0] junk;
    logic          mem_clear;

    always @(posedge clk) begin
        junk <= $urandom;
        for (int i = L - 1; i > 0; i--) begin
            dpipe[i] <= dpipe[i-1];
            vpipe[i] <= vpipe[i-1];
        end
        dpipe[0] <= bmem[addr_a[3:0]];
        vpipe[0] <= en_a && (we_a == 4'b0000);
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) bmem[i] <= '0;
        end else if (en_a) begin
            for (int b = 0; b < 4; b++) begin
                if (we_a[b]) bmem[addr_a[3:0]][8*b +: 8] <= wrdata_a[8*b +: 8];
            end
        end
    end

    assign rddata_a = vpipe[L-1] ? dpipe[L-1] : junk;

    // Reference model state (command level).
    logic [DW-1:0] ref_mem [16];
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;
    logic [DW-1:0] last_rdata;
    bit            done_flag;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, en_a, 0);
        check({tag, "_we"}, we_a, 0);
        check({tag, "_start"}, start, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rdata"}, rsp_rdata, 0);
        check({tag, "_timeout"}, rsp_timeout, 0);
        check({tag, "_addr"}, addr_a, 0);
        check({tag, "_wrdata"}, wrdata_a, 0);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [3:0] be,
                           input int done_at, input bit hold);
        int            exp_k;
        int            k;
        int            wait_n;
        logic [DW-1:0] exp_rd;
        bit            exp_to;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        bit            seen;

        case (op)
            OP_WRITE: exp_k = 2;
            OP_READ:  exp_k = 2 + L;
            OP_START: exp_k = 2;
            default:  exp_k = done_flag ? 2 : (done_at > 0 ? done_at + 1 : (1 << TW));
        endcase
        exp_rd    = (op == OP_READ) ? ref_mem[addr[3:0]] : '0;
        exp_to    = (op == OP_WAIT) && !done_flag && (done_at == 0);
        exp_addr  = (op == OP_WRITE || op == OP_READ) ? addr : last_addr;
        exp_wdata = (op == OP_WRITE) ? wdata : last_wdata;

        @(negedge clk);
        done = 1'b0;
        check("idle_ready", cmd_ready, 1);
        check("rdata_hold", rsp_rdata, last_rdata);
        check("idle_rsp", rsp_valid, 0);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_be    = be;
        wait_n = 0;
        while (!cmd_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check("accept", cmd_ready, 1);

        seen = 1'b0;
        for (k = 1; k <= exp_k + 20; k++) begin
            @(negedge clk);
            if (!hold) cmd_valid = 1'b0;
            check("busy_ready", cmd_ready, 0);
            check("en_a", en_a, ((op == OP_WRITE || op == OP_READ) && k == 1) ? 1 : 0);
            check("we_a", we_a, (op == OP_WRITE && k == 1) ? be : 4'b0000);
            check("start", start, (op == OP_START && k == 1) ? 1 : 0);
            if (k == 1) begin
                check("addr_a", addr_a, exp_addr);
                check("wrdata_a", wrdata_a, exp_wdata);
            end
            done = (k == done_at);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("rsp_seen", seen, 1);
        check("rsp_cycle", k, exp_k);
        if (seen) begin
            check("rsp_rdata", rsp_rdata, exp_rd);
            check("rsp_timeout", rsp_timeout, exp_to);
        end
        $display("cmd op=%0d addr=%06h wdata=%08h be=%h done_at=%0d hold=%0d rsp_cycle=%0d rdata=%08h",
                 op, addr, wdata, be, done_at, hold, k, rsp_rdata);

        case (op)
            OP_WRITE: begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) ref_mem[addr[3:0]][8*b +: 8] = wdata[8*b +: 8];
                end
                if (done_at > 0) done_flag = 1'b1;
            end
            OP_READ:  if (done_at > 0) done_flag = 1'b1;
            OP_START: done_flag = (done_at == exp_k);
            default:  done_flag = 1'b0;
        endcase
        last_addr  = exp_addr;
        last_wdata = exp_wdata;
        last_rdata = exp_rd;
    endtask

    task automatic pulse_done_idle(input int gap);
        @(negedge clk);
        cmd_valid = 1'b0;
        done = 1'b0;
        repeat (gap) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        done_flag = 1'b1;
        $display("done pulse after %0d idle cycles", gap);
    endtask

    task automatic reset_mid_read(input logic [AW-1:0] addr);
        @(negedge clk);
        done      = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_READ;
        cmd_addr  = addr;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", cmd_ready, 1);
        for (int i = 0; i < 2 * L + 2; i++) begin
            check("midrst_no_rsp", rsp_valid, 0);
            @(negedge clk);
        end
        last_addr  = '0;
        last_wdata = '0;
        last_rdata = '0;
        done_flag  = 1'b0;
        $display("reset during read wait, addr=%06h", addr);
    endtask

    initial begin
        logic [1:0]    op;
        logic [AW-1:0] addr;
        int            done_at;

        rst       = 1'b1;
        mem_clear = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_be    = 4'h0;
        done      = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        last_addr  = '0;
        last_wdata = '0;
        last_rdata = '0;
        done_flag  = 1'b0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst       = 1'b0;
        mem_clear = 1'b0;
        @(negedge clk);
        check("reset_ready", cmd_ready, 1);

        // Directed cases.
        run_cmd(OP_WRITE, 22'h000100, 32'hA5A5_1234, 4'hF, 0, 1'b0);
        run_cmd(OP_READ,  22'h000100, '0, 4'h0, 0, 1'b0);
        run_cmd(OP_WRITE, 22'h000104, 32'hDEAD_BEEF, 4'hF, 0, 1'b1);
        run_cmd(OP_READ,  22'h000104, '0, 4'h0, 0, 1'b1);
        run_cmd(OP_WRITE, 22'h000104, 32'h1111_1111, 4'h0, 0, 1'b0);
        run_cmd(OP_WRITE, 22'h000104, 32'h2233_4455, 4'h5, 0, 1'b0);
        run_cmd(OP_READ,  22'h000104, '0, 4'h0, 0, 1'b0);
        run_cmd(OP_START, '0, '0, 4'h0, 0, 1'b0);
        pulse_done_idle(5);
        run_cmd(OP_WAIT,  '0, '0, 4'h0, 0, 1'b0);
        run_cmd(OP_START, '0, '0, 4'h0, 1, 1'b0);
        run_cmd(OP_WAIT,  '0, '0, 4'h0, 3, 1'b0);
        run_cmd(OP_START, '0, '0, 4'h0, 2, 1'b0);
        run_cmd(OP_WAIT,  '0, '0, 4'h0, 0, 1'b0);
`ifdef BRAM_HOST_TIMEOUT_EN
        run_cmd(OP_WAIT,  '0, '0, 4'h0, 0, 1'b0);
`endif
        reset_mid_read(22'h000100);
        run_cmd(OP_READ,  22'h000100, '0, 4'h0, 0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            op   = 2'($urandom_range(0, 3));
            addr = AW'($urandom);
            case (op)
                OP_WRITE: done_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                OP_READ:  done_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 + L) : 0;
                OP_START: done_at = $urandom_range(0, 2);
                default: begin
                    if (done_flag) done_at = 0;
`ifdef BRAM_HOST_TIMEOUT_EN
                    else done_at = $urandom_range(0, 6);
`else
                    else done_at = $urandom_range(1, 6);
`endif
                end
            endcase
            run_cmd(op, addr, $urandom, 4'($urandom_range(0, 15)), done_at, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        cmd_valid = 1'b0;
        done = 1'b0;
        check("final_rdata_hold", rsp_rdata, last_rdata);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
